// File: rtl/lsu_controller.sv
// -----------------------------------------------------------------------------
// lsu_controller
//
// Load/store unit sequencer that sits between the execute stage and a
// handshake-style data memory. Each access runs through a three-state FSM
// (IDLE -> REQ -> DONE). Request fields are registered on entry to REQ and held
// until the memory acknowledges. Load data is lane-extracted and sign- or
// zero-extended when the acknowledge arrives. A wait counter bounds the time
// spent in REQ and reports a bus error when it expires.
//
// Ports
//   clk         in   1   sole clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   mem_read    in   1   current instruction is a load
//   mem_write   in   1   current instruction is a store (wins over mem_read)
//   funct3      in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr        in  32   byte address from the ALU
//   store_data  in  32   rs2 value to be stored
//   dm_rdata    in  32   data memory read word
//   dm_ack      in   1   data memory completion pulse
//   dm_req      out  1   access request to data memory
//   dm_we       out  1   1 = write access
//   dm_addr     out 32   word-aligned address
//   dm_wdata    out 32   lane-replicated store data
//   dm_wmask    out  4   byte-lane write enables
//   load_data   out 32   extended load result for write-back
//   stall       out  1   freeze PC and register-file write
//   misaligned  out  1   misaligned access flag (one cycle, no request issued)
//   bus_err     out  1   one-cycle pulse when the memory fails to acknowledge
//
// Parameter
//   TIMEOUT     number of REQ cycles without dm_ack before the access is
//               abandoned (legal range 1..255, the wait counter is 8 bits)
// -----------------------------------------------------------------------------
module lsu_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wmask,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Access size encoding used internally
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Any funct3 encoding other than the byte and half forms is a word access.
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            3'b000, 3'b100: sz = SZ_BYTE;
            3'b001, 3'b101: sz = SZ_HALF;
            default:        sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicating the low bytes across the word lets the mask alone pick the lane.
    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_cnt_d;
    logic        dm_req_q;
    logic        dm_we_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_wdata_q;
    logic [3:0]  dm_wmask_q;
    logic [31:0] load_data_q;
    logic        bus_err_q;

    // Context of the in-flight access, needed when the load data returns
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;

    // -------------------------------------------------------------------------
    // Decode of the instruction currently presented
    // -------------------------------------------------------------------------
    logic        access_pending;
    logic        is_store;
    logic [1:0]  size;
    logic        aligned;
    logic        issue;
    logic        misalign_now;
    logic        timeout_hit;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] load_ext;

    always_comb begin
        access_pending = mem_read | mem_write;
        is_store       = mem_write;
        size           = access_size(funct3);
        aligned        = is_aligned(size, addr[1:0]);
        issue          = (state_q == ST_IDLE) & access_pending & aligned;
        misalign_now   = (state_q == ST_IDLE) & access_pending & ~aligned;
        wmask_d        = store_mask(size, addr[1:0]);
        wdata_d        = store_wdata(size, store_data);
        load_ext       = load_extract(funct3_q, off_q, dm_rdata);
        wait_cnt_d     = wait_cnt_q + 8'd1;
        // Fires on the REQ cycle whose increment would reach TIMEOUT, so the
        // request has been presented for exactly TIMEOUT cycles.
        timeout_hit    = (wait_cnt_d == TIMEOUT_CNT);
    end

    // stall must rise in the same cycle the access is first seen, before the
    // request register has had a chance to load, hence the combinational term.
    assign stall      = ~rst & (issue | (state_q == ST_REQ));
    assign misaligned = ~rst & misalign_now;
    // A rejected access reports a zero result during the cycle it is flagged.
    assign load_data  = misaligned ? 32'd0 : load_data_q;

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign dm_wmask = dm_wmask_q;
    assign bus_err  = bus_err_q;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 8'd0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= 32'd0;
            dm_wdata_q  <= 32'd0;
            dm_wmask_q  <= 4'd0;
            load_data_q <= 32'd0;
            bus_err_q   <= 1'b0;
            off_q       <= 2'd0;
            funct3_q    <= 3'd0;
            is_load_q   <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q    <= ST_REQ;
                        wait_cnt_q <= 8'd0;
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= is_store;
                        dm_addr_q  <= {addr[31:2], 2'b00};
                        dm_wmask_q <= is_store ? wmask_d : 4'd0;
                        dm_wdata_q <= is_store ? wdata_d : 32'd0;
                        off_q      <= addr[1:0];
                        funct3_q   <= funct3;
                        is_load_q  <= ~is_store;
                    end else if (misalign_now && !is_store) begin
                        load_data_q <= 32'd0;
                    end
                end

                ST_REQ: begin
                    // Acknowledge is checked first so it wins over a
                    // simultaneous timeout.
                    if (dm_ack) begin
                        if (is_load_q) begin
                            load_data_q <= load_ext;
                        end
                        dm_req_q   <= 1'b0;
                        dm_we_q    <= 1'b0;
                        dm_wmask_q <= 4'd0;
                        state_q    <= ST_DONE;
                    end else if (timeout_hit) begin
                        dm_req_q    <= 1'b0;
                        dm_we_q     <= 1'b0;
                        dm_wmask_q  <= 4'd0;
                        bus_err_q   <= 1'b1;
                        load_data_q <= 32'd0;
                        state_q     <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                // One cycle with stall low lets the pipeline advance, so the
                // same instruction is never re-issued on return to IDLE.
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] dm_rdata = 32'd0;
    logic        dm_ack = 1'b0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wmask;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        bus_err;

    always #5 clk = ~clk;

    lsu_controller #(.TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_wmask   (dm_wmask),
        .load_data  (load_data),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] ld;
        logic        berr;
        int          stall_cyc;
        int          req_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access; the expected outcome is queued at drive time and
    // popped when the DUT reaches the completion cycle (stall low again).
    // ack_dly < 0 withholds the acknowledge entirely.
    task automatic run_access(input string       tag,
                              input logic        rd,
                              input logic        wr,
                              input logic [2:0]  f3,
                              input logic [31:0] a,
                              input logic [31:0] sd,
                              input logic [31:0] rdata,
                              input int          ack_dly,
                              input logic [31:0] exp_ld,
                              input logic        exp_berr,
                              input logic [31:0] exp_daddr,
                              input logic [3:0]  exp_mask,
                              input logic [31:0] exp_wdata);
        exp_t e;
        int   stall_cyc;
        int   req_cyc;
        bit   done;
        stall_cyc   = 0;
        req_cyc     = 0;
        done        = 1'b0;
        e.tag       = tag;
        e.ld        = exp_ld;
        e.berr      = exp_berr;
        e.req_cyc   = (ack_dly < 0) ? 255 : ack_dly + 1;
        e.stall_cyc = e.req_cyc + 1;

        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dm_ack     = 1'b0;
        dm_rdata   = 32'hDEAD_BEEF;
        sb.push_back(e);
        #1;
        chk({tag, ".idle_req"}, dm_req, 1'b0);
        if (stall) stall_cyc++;

        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            dm_ack   = 1'b0;
            dm_rdata = 32'hDEAD_BEEF;
            #1;
            if (!stall) begin
                done      = 1'b1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                e = sb.pop_front();
                chk({e.tag, ".done_req"}, dm_req, 1'b0);
                chk({e.tag, ".load_data"}, load_data, e.ld);
                chk({e.tag, ".bus_err"}, bus_err, e.berr);
                chk({e.tag, ".stall_cycles"}, stall_cyc, e.stall_cyc);
                chk({e.tag, ".req_cycles"}, req_cyc, e.req_cyc);
            end else begin
                stall_cyc++;
                if (dm_req) begin
                    chk({tag, ".dm_addr"}, dm_addr, exp_daddr);
                    chk({tag, ".dm_we"}, dm_we, wr);
                    chk({tag, ".dm_wmask"}, dm_wmask, exp_mask);
                    if (wr) chk({tag, ".dm_wdata"}, dm_wdata, exp_wdata);
                    if (req_cyc == ack_dly) begin
                        dm_ack   = 1'b1;
                        dm_rdata = rdata;
                    end
                    req_cyc++;
                end
            end
        end
        chk({tag, ".completed"}, done, 1'b1);
        if (!done) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            void'(sb.pop_front());
        end

        @(negedge clk);
        #1;
        chk({tag, ".after_bus_err"}, bus_err, 1'b0);
        chk({tag, ".after_stall"}, stall, 1'b0);
        chk({tag, ".after_req"}, dm_req, 1'b0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.dm_req", dm_req, 1'b0);
        chk("rst.dm_we", dm_we, 1'b0);
        chk("rst.dm_wmask", dm_wmask, 4'd0);
        chk("rst.stall", stall, 1'b0);
        chk("rst.misaligned", misaligned, 1'b0);
        chk("rst.bus_err", bus_err, 1'b0);
        chk("rst.load_data", load_data, 32'd0);
        chk("rst.dm_addr", dm_addr, 32'd0);
        chk("rst.dm_wdata", dm_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Loads, each lane/extension variant
        run_access("lb_1003", 1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 0,
                   32'hFFFF_FF80, 0, 32'h0000_1000, 4'h0, 32'd0);
        run_access("lbu_1001", 1, 0, 3'b100, 32'h0000_1001, 32'd0, 32'h80FF_FF12, 2,
                   32'h0000_00FF, 0, 32'h0000_1000, 4'h0, 32'd0);
        run_access("lh_1002", 1, 0, 3'b001, 32'h0000_1002, 32'd0, 32'h80FF_FF12, 1,
                   32'hFFFF_80FF, 0, 32'h0000_1000, 4'h0, 32'd0);
        run_access("lhu_1000", 1, 0, 3'b101, 32'h0000_1000, 32'd0, 32'h80FF_FF12, 0,
                   32'h0000_FF12, 0, 32'h0000_1000, 4'h0, 32'd0);
        run_access("lw_1004", 1, 0, 3'b010, 32'h0000_1004, 32'd0, 32'h1234_5678, 0,
                   32'h1234_5678, 0, 32'h0000_1004, 4'h0, 32'd0);
        run_access("l011_1008", 1, 0, 3'b011, 32'h0000_1008, 32'd0, 32'hCAFE_F00D, 0,
                   32'hCAFE_F00D, 0, 32'h0000_1008, 4'h0, 32'd0);
        run_access("l110_100c", 1, 0, 3'b110, 32'h0000_100C, 32'd0, 32'h89AB_CDEF, 1,
                   32'h89AB_CDEF, 0, 32'h0000_100C, 4'h0, 32'd0);

        // Stores: load_data must keep the last load result
        run_access("sh_2002", 0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h1111_1111, 0,
                   32'h89AB_CDEF, 0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
        run_access("sb_2001", 0, 1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 32'h1111_1111, 0,
                   32'h89AB_CDEF, 0, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5);
        run_access("sw_2004", 0, 1, 3'b010, 32'h0000_2004, 32'h0123_4567, 32'h1111_1111, 1,
                   32'h89AB_CDEF, 0, 32'h0000_2004, 4'b1111, 32'h0123_4567);
        run_access("rw_sb_2003", 1, 1, 3'b000, 32'h0000_2003, 32'h0000_005A, 32'h2222_2222, 0,
                   32'h89AB_CDEF, 0, 32'h0000_2000, 4'b1000, 32'h5A5A_5A5A);

        // Acknowledge while idle is ignored
        @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_ack.stall", stall, 1'b0);
        chk("idle_ack.req", dm_req, 1'b0);
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        chk("idle_ack.load_data", load_data, 32'h89AB_CDEF);
        chk("idle_ack.req2", dm_req, 1'b0);

        // Misaligned accesses
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_3001;
        #1;
        chk("mis_lw.misaligned", misaligned, 1'b1);
        chk("mis_lw.stall", stall, 1'b0);
        chk("mis_lw.load_data", load_data, 32'd0);
        chk("mis_lw.req", dm_req, 1'b0);
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        chk("mis_lw.misaligned_clr", misaligned, 1'b0);
        chk("mis_lw.req_after", dm_req, 1'b0);
        chk("mis_lw.load_after", load_data, 32'd0);

        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b001;
        addr     = 32'h0000_3003;
        #1;
        chk("mis_lh.misaligned", misaligned, 1'b1);
        chk("mis_lh.stall", stall, 1'b0);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_2006;
        #1;
        chk("mis_sw.misaligned", misaligned, 1'b1);
        chk("mis_sw.stall", stall, 1'b0);
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        chk("mis_sw.req", dm_req, 1'b0);

        // Timeout, then ack coinciding with the timeout cycle
        run_access("lhu_timeout", 1, 0, 3'b101, 32'h0000_0010, 32'd0, 32'd0, -1,
                   32'd0, 1, 32'h0000_0010, 4'h0, 32'd0);
        run_access("lw_ack_at_limit", 1, 0, 3'b010, 32'h0000_0014, 32'd0, 32'h0BAD_F00D, 254,
                   32'h0BAD_F00D, 0, 32'h0000_0014, 4'h0, 32'd0);

        // Reset in the middle of a request
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0040;
        @(negedge clk);
        #1;
        chk("rst_mid.req_before", dm_req, 1'b1);
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        chk("rst_mid.req", dm_req, 1'b0);
        chk("rst_mid.stall", stall, 1'b0);
        chk("rst_mid.dm_addr", dm_addr, 32'd0);
        chk("rst_mid.load_data", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = 32'h1234_5678;
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        chk("rst_mid.no_capture", load_data, 32'd0);
        chk("rst_mid.req_after", dm_req, 1'b0);
        chk("rst_mid.stall_after", stall, 1'b0);

        // Restart from IDLE with minimum latency
        run_access("lb_restart", 1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 0,
                   32'hFFFF_FF80, 0, 32'h0000_1000, 4'h0, 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
